// File: rtl/out_serializer_if.sv
// Beat-in / sample-out bus of the FFT output serializer.
// master = serializer side, slave = upstream commutator plus downstream sink.
interface out_serializer_if #(
  parameter int unsigned nb = 16
);
  logic            start;
  logic [nb*4-1:0] input_data;
  logic [nb-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic            overflow;

  modport master (
    input  start,
    input  input_data,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_last,
    output overflow
  );

  modport slave (
    output start,
    output input_data,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  overflow
  );
endinterface

// File: rtl/out_serializer.sv
// FFT output serializer: captures FRAME/4 four-lane beats into a ping-pong buffer and
// re-emits each frame as a serial valid/ready stream with a last flag. FRAME must be >= 8.
module out_serializer #(
  parameter int unsigned nb    = 16,
  parameter int unsigned FRAME = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  out_serializer_if.master bus
);
  localparam int unsigned BEATS = FRAME / 4;
  localparam int unsigned BeatW = $clog2(BEATS);
  localparam int unsigned SmpW  = $clog2(FRAME);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);
  localparam logic [SmpW-1:0]  LastSmp  = SmpW'(FRAME - 1);

  typedef enum logic {WIdle, WFill} wr_state_e;
  typedef enum logic {RIdle, RDrain} rd_state_e;

  // Banks hold whole beats; lane3 of a beat is the lowest sample index.
  logic [nb*4-1:0] mem [2][BEATS];

  wr_state_e        wr_state_q, wr_state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             overflow_q, overflow_d;
  logic             mem_we;
  logic [1:0]       set_mask, free_mask, avail;

  rd_state_e        rd_state_q, rd_state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [SmpW-1:0]  smp_q, smp_d;
  logic [nb-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             transfer;
  logic             load;
  logic             load_bank;
  logic [SmpW-1:0]  load_idx;
  logic [nb*4-1:0]  load_word;
  logic [1:0]       load_lane;

  assign transfer = valid_q & bus.out_ready;

  // Read side: presents one registered sample at a time and frees a bank on its last transfer.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    smp_d      = smp_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    free_mask  = '0;
    load       = 1'b0;
    load_bank  = rd_bank_q;
    load_idx   = '0;
    case (rd_state_q)
      RIdle: begin
        if (bank_full_q[rd_bank_q]) begin
          rd_state_d = RDrain;
          load       = 1'b1;
        end
      end
      RDrain: begin
        if (transfer) begin
          if (last_q) begin
            free_mask[rd_bank_q] = 1'b1;
            rd_bank_d            = ~rd_bank_q;
            if (bank_full_q[~rd_bank_q]) begin
              load      = 1'b1;
              load_bank = ~rd_bank_q;
            end else begin
              rd_state_d = RIdle;
              valid_d    = 1'b0;
              last_d     = 1'b0;
            end
          end else begin
            load     = 1'b1;
            load_idx = smp_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
    load_word = mem[load_bank][load_idx[SmpW-1:2]];
    load_lane = 2'd3 - load_idx[1:0];
    if (load) begin
      smp_d   = load_idx;
      data_d  = load_word[32'(load_lane) * nb +: nb];
      valid_d = 1'b1;
      last_d  = (load_idx == LastSmp);
    end
  end

  // A bank being freed this cycle may be claimed by a start in the same cycle.
  assign avail = ~bank_full_q | free_mask;

  always_comb begin
    wr_state_d = wr_state_q;
    beat_d     = beat_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    set_mask   = '0;
    case (wr_state_q)
      WIdle: begin
        if (bus.start) begin
          if (avail[wr_bank_q]) begin
            wr_state_d = WFill;
            beat_d     = '0;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      WFill: begin
        mem_we = 1'b1;
        if (beat_q == LastBeat) begin
          set_mask[wr_bank_q] = 1'b1;
          wr_bank_d           = ~wr_bank_q;
          beat_d              = '0;
          wr_state_d          = WIdle;
          // start alongside the final beat opens the next frame in the other bank
          if (bus.start) begin
            if (avail[~wr_bank_q]) begin
              wr_state_d = WFill;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end else if (bus.start) begin
          beat_d     = '0;
          overflow_d = 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bank_full_d = (bank_full_q & ~free_mask) | set_mask;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_bank_q][beat_q] <= bus.input_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q  <= WIdle;
      beat_q      <= '0;
      wr_bank_q   <= 1'b0;
      bank_full_q <= '0;
      overflow_q  <= 1'b0;
      rd_state_q  <= RIdle;
      rd_bank_q   <= 1'b0;
      smp_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      beat_q      <= beat_d;
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
      rd_state_q  <= rd_state_d;
      rd_bank_q   <= rd_bank_d;
      smp_q       <= smp_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.overflow  = overflow_q;

endmodule
